// File: rtl/pipelined_memory_unit.sv
// Byte-addressed data memory for the load/store path: sub-word loads/stores, sign/zero extension,
// alignment faults, fixed-latency in-order responses, and a post-reset clear sequence.
module pipelined_memory_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_BITS-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]   req_store_data,
    output logic                    resp_valid,
    output logic                    resp_store,
    output logic                    resp_fault,
    output logic [ADDRESS_BITS-1:0] resp_address,
    output logic [DATA_WIDTH-1:0]   resp_load_data,
    input  logic                    report
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_BITS  = ADDRESS_BITS - LANE_BITS;
    localparam int MEM_DEPTH = 1 << IDX_BITS;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    typedef struct packed {
        logic                    valid;
        logic                    store;
        logic                    fault;
        logic [ADDRESS_BITS-1:0] address;
        logic [DATA_WIDTH-1:0]   data;
    } resp_t;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   clear_idx_q, clear_idx_d;
    logic [31:0]           cycle_q, cycle_d;
    resp_t                 pipe_q [READ_LATENCY];
    resp_t                 pipe_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
    logic                  clear_we;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first in every combinational block; a path that leaves
        // a variable unassigned would otherwise infer a latch.
        state_d = state_q;
        if (state_q == ST_CLEAR && clear_idx_q == IDX_BITS'(MEM_DEPTH - 1)) begin
            state_d = ST_READY;
        end
    end

    always_comb begin
        req_ready = (state_q == ST_READY);
        clear_we  = (state_q == ST_CLEAR);
    end

    // ---------------- request decode ----------------
    logic                  accept;
    logic [IDX_BITS-1:0]   word_idx;
    int                    lane_int;
    int                    size_bytes;
    int                    nbits;
    logic                  fault;
    logic [DATA_WIDTH-1:0] rd_word, field, mask, load_data;
    logic                  sign;

    always_comb begin
        accept     = req_valid & req_ready;
        word_idx   = req_address[ADDRESS_BITS-1:LANE_BITS];
        lane_int   = int'(req_address[LANE_BITS-1:0]);
        size_bytes = 1 << req_size;
        fault      = (size_bytes > BYTES) || ((lane_int % size_bytes) != 0);
        rd_word    = mem_q[word_idx];
        field      = rd_word >> (8 * lane_int);
        nbits      = (8 * size_bytes > DATA_WIDTH) ? DATA_WIDTH : 8 * size_bytes;
        mask       = '0;
        sign       = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (i < nbits);
            if (i == nbits - 1) sign = field[i];
        end
        // Full-width loads have an all-ones mask, so the extension term vanishes.
        load_data = (field & mask) | ((!req_unsigned && sign) ? ~mask : '0);
    end

    // ---------------- memory write port ----------------
    logic                  wr_en;
    logic [IDX_BITS-1:0]   wr_idx;
    logic [BYTES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clear_idx_q;
        wr_be   = '0;
        wr_data = '0;
        if (clear_we) begin
            wr_en = 1'b1;
            wr_be = '1;
        end else if (accept && req_store && !fault) begin
            wr_en   = 1'b1;
            wr_idx  = word_idx;
            wr_data = req_store_data << (8 * lane_int);
            for (int b = 0; b < BYTES; b++) begin
                wr_be[b] = (b >= lane_int) && (b < lane_int + size_bytes);
            end
        end
    end

    // NOTE: the array has no reset; the CLEAR sequence zeroes it, keeping it mappable to RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- response pipeline ----------------
    always_comb begin
        clear_idx_d = clear_we ? clear_idx_q + 1'b1 : clear_idx_q;
        cycle_d     = cycle_q + 32'd1;
        pipe_d[0]   = '0;
        if (accept) begin
            pipe_d[0].valid   = 1'b1;
            pipe_d[0].store   = req_store;
            pipe_d[0].fault   = fault;
            pipe_d[0].address = req_address;
            pipe_d[0].data    = (req_store || fault) ? '0 : load_data;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_idx_q <= '0;
            cycle_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            clear_idx_q <= clear_idx_d;
            cycle_q     <= cycle_d;
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign resp_valid     = pipe_q[READ_LATENCY-1].valid;
    assign resp_store     = pipe_q[READ_LATENCY-1].store;
    assign resp_fault     = pipe_q[READ_LATENCY-1].fault;
    assign resp_address   = pipe_q[READ_LATENCY-1].address;
    assign resp_load_data = pipe_q[READ_LATENCY-1].data;

    // Report hook: core id, request and cycle count are only observed by simulation tooling.
    logic [31:0] core_id;
    logic        unused_report;
    assign core_id       = CORE;
    assign unused_report = ^{report, cycle_q, core_id};

endmodule
